write_fifo_multichannel: RTL and testbench

- Parametrised multi-channel write sink for the PipeArch memory path.
- Accepts a configured number of lines from N internal write sources and pushes them into one FIFO/BRAM write port.
- Two modes:
  - Single-channel: one selected source.
  - Strict round-robin interleave: line i comes from channel i mod N.
- Adds busy/done status and a running line count for the controller.

---
 rtl/write_fifo_pkg.sv | 25 ++
 rtl/write_fifo_chsel.sv | 38 +++
 rtl/write_fifo_multichannel.sv | 148 ++++++++++++++
 tb/tb_write_fifo_multichannel.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/write_fifo_pkg.sv
// Shared types and config-register field positions for the multi-channel write sink.
package write_fifo_pkg;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_RUN  = 1'b1
  } t_wf_state;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_RR     = 2'b01
  } t_wf_mode;

  // configreg field positions
  localparam int unsigned LEN_MSB  = 31;
  localparam int unsigned LEN_LSB  = 16;
  localparam int unsigned CH_MSB   = 7;
  localparam int unsigned CH_LSB   = 4;
  localparam int unsigned MODE_MSB = 1;
  localparam int unsigned MODE_LSB = 0;

  // Width of a channel index (supports up to 16 channels)
  localparam int unsigned WF_CH_W  = CH_MSB - CH_LSB + 1;

endpackage

// File: rtl/write_fifo_chsel.sv
// Combinational N:1 source selector plus per-channel backpressure generation.
module write_fifo_chsel
  import write_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned NUM_CHANNELS = 4
) (
  input  logic [WF_CH_W-1:0]                 i_active,
  input  logic                               i_run,
  input  logic                               i_fifo_almostfull,
  input  logic [NUM_CHANNELS-1:0]            i_we,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_wdata,
  output logic                               o_sel_we_c,
  output logic [DATA_WIDTH-1:0]              o_sel_wdata_c,
  output logic [NUM_CHANNELS-1:0]            o_almostfull_c
);

  // Pick strobe and data of the active channel
  always_comb begin
    o_sel_we_c    = 1'b0;
    o_sel_wdata_c = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (i_active == WF_CH_W'(c)) begin
        o_sel_we_c    = i_we[c];
        o_sel_wdata_c = i_wdata[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Every source except the one whose turn it is sees backpressure
  always_comb begin
    o_almostfull_c = '1;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      o_almostfull_c[c] = i_fifo_almostfull | ~(i_run & (i_active == WF_CH_W'(c)));
    end
  end

endmodule

// File: rtl/write_fifo_multichannel.sv
// Multi-channel write sink: collects a configured number of lines from one
// source or round-robin across sources and pushes them into a single FIFO port.
module write_fifo_multichannel
  import write_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned LEN_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               op_start,
  input  logic [31:0]                        configreg,
  input  logic [NUM_CHANNELS-1:0]            in_we,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_wdata,
  output logic [NUM_CHANNELS-1:0]            in_almostfull,
  input  logic                               fifo_almostfull,
  output logic                               fifo_we,
  output logic [DATA_WIDTH-1:0]              fifo_wdata,
  output logic                               busy,
  output logic                               done,
  output logic [LEN_WIDTH-1:0]               lines_written
);

  localparam int unsigned CH_W = WF_CH_W;

  t_wf_state             r_state, w_state_nxt;
  t_wf_mode              r_mode, w_mode_nxt, w_cfg_mode;
  logic [LEN_WIDTH-1:0]  r_len, w_len_nxt, r_count, w_count_nxt, w_cfg_len;
  logic [CH_W-1:0]       r_ch, w_ch_nxt, r_rr, w_rr_nxt, w_cfg_ch, w_active;
  logic                  r_fifo_we, w_fifo_we_nxt, r_done, w_done_nxt;
  logic [DATA_WIDTH-1:0] r_fifo_wdata, w_wdata_nxt;
  logic                  w_run, w_sel_we, w_accept, w_last, w_reject;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_unused;

  // Decode the configuration word presented with op_start
  assign w_cfg_len  = LEN_WIDTH'(configreg[LEN_MSB:LEN_LSB]);
  assign w_cfg_ch   = configreg[CH_MSB:CH_LSB];
  assign w_cfg_mode = (configreg[MODE_MSB:MODE_LSB] == MODE_RR) ? MODE_RR : MODE_SINGLE;
  assign w_unused   = ^{configreg[15:8], configreg[3:2]};

  // Zero-length or out-of-range single-channel requests finish without running
  assign w_reject = (w_cfg_len == '0) ||
                    ((w_cfg_mode == MODE_SINGLE) && ((CH_W+1)'(w_cfg_ch) >= (CH_W+1)'(NUM_CHANNELS)));

  assign w_run    = (r_state == STATE_RUN);
  assign w_active = (r_mode == MODE_RR) ? r_rr : r_ch;
  assign w_accept = w_run && w_sel_we && (r_count < r_len);
  assign w_last   = (r_count == (r_len - LEN_WIDTH'(1)));

  write_fifo_chsel #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_chsel (
    .i_active         (w_active),
    .i_run            (w_run),
    .i_fifo_almostfull(fifo_almostfull),
    .i_we             (in_we),
    .i_wdata          (in_wdata),
    .o_sel_we_c       (w_sel_we),
    .o_sel_wdata_c    (w_sel_wdata),
    .o_almostfull_c   (in_almostfull)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= STATE_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      STATE_IDLE: if (op_start && !w_reject)  w_state_nxt = STATE_RUN;
      STATE_RUN:  if (w_accept && w_last)     w_state_nxt = STATE_IDLE;
      default:                                w_state_nxt = STATE_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_fifo_we_nxt = 1'b0;
    w_wdata_nxt   = r_fifo_wdata;
    w_done_nxt    = 1'b0;
    w_count_nxt   = r_count;
    w_rr_nxt      = r_rr;
    w_len_nxt     = r_len;
    w_ch_nxt      = r_ch;
    w_mode_nxt    = r_mode;
    case (r_state)
      STATE_IDLE: begin
        if (op_start) begin
          w_len_nxt   = w_cfg_len;
          w_ch_nxt    = w_cfg_ch;
          w_mode_nxt  = w_cfg_mode;
          w_count_nxt = '0;
          w_rr_nxt    = '0;
          w_done_nxt  = w_reject;
        end
      end
      STATE_RUN: begin
        if (w_accept) begin
          w_fifo_we_nxt = 1'b1;
          w_wdata_nxt   = w_sel_wdata;
          w_count_nxt   = r_count + LEN_WIDTH'(1);
          w_done_nxt    = w_last;
          w_rr_nxt      = (r_rr == CH_W'(NUM_CHANNELS - 1)) ? '0 : r_rr + CH_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Control and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fifo_we <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
      r_rr      <= '0;
      r_len     <= '0;
      r_ch      <= '0;
      r_mode    <= MODE_SINGLE;
    end else begin
      r_fifo_we <= w_fifo_we_nxt;
      r_done    <= w_done_nxt;
      r_count   <= w_count_nxt;
      r_rr      <= w_rr_nxt;
      r_len     <= w_len_nxt;
      r_ch      <= w_ch_nxt;
      r_mode    <= w_mode_nxt;
    end
  end

  // Write data needs no reset; it is only meaningful alongside fifo_we
  always_ff @(posedge clk) begin
    r_fifo_wdata <= w_wdata_nxt;
  end

  assign fifo_we       = r_fifo_we;
  assign fifo_wdata    = r_fifo_wdata;
  assign done          = r_done;
  assign busy          = w_run;
  assign lines_written = r_count;

endmodule

// File: tb/tb_write_fifo_multichannel.sv
// Directed, table-driven bench for write_fifo_multichannel (4 channels, 32-bit lines).
module tb_write_fifo_multichannel;

  localparam int unsigned DW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned LW = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             op_start;
  logic [31:0]      configreg;
  logic [NC-1:0]    in_we;
  logic [NC*DW-1:0] in_wdata;
  logic [NC-1:0]    in_almostfull;
  logic             fifo_almostfull;
  logic             fifo_we;
  logic [DW-1:0]    fifo_wdata;
  logic             busy;
  logic             done;
  logic [LW-1:0]    lines_written;

  int n_checks = 0;
  int n_fail   = 0;

  write_fifo_multichannel #(
    .DATA_WIDTH  (DW),
    .NUM_CHANNELS(NC),
    .LEN_WIDTH   (LW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .op_start       (op_start),
    .configreg      (configreg),
    .in_we          (in_we),
    .in_wdata       (in_wdata),
    .in_almostfull  (in_almostfull),
    .fifo_almostfull(fifo_almostfull),
    .fifo_we        (fifo_we),
    .fifo_wdata     (fifo_wdata),
    .busy           (busy),
    .done           (done),
    .lines_written  (lines_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic [31:0] cfg;
    logic [3:0]  we;
    logic [7:0]  d;
    logic        faf;
    logic        e_we;
    logic [31:0] e_data;
    logic        e_done;
    logic        e_busy;
    logic [15:0] e_cnt;
    logic [3:0]  e_af;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic start, input logic [31:0] cfg,
                              input logic [3:0] we, input logic [7:0] d, input logic faf,
                              input logic e_we, input logic [31:0] e_data, input logic e_done,
                              input logic e_busy, input logic [15:0] e_cnt, input logic [3:0] e_af);
    vec_t v;
    v.rst = rst; v.start = start; v.cfg = cfg; v.we = we; v.d = d; v.faf = faf;
    v.e_we = e_we; v.e_data = e_data; v.e_done = e_done; v.e_busy = e_busy;
    v.e_cnt = e_cnt; v.e_af = e_af;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Channel c carries (c << 8) | d so the source of each line is visible in the data
  task automatic set_data(input logic [7:0] d);
    for (int c = 0; c < int'(NC); c++) begin
      in_wdata[c*DW +: DW] = 32'((c << 8) | int'(d));
    end
  endtask

  initial begin
    int writes, dones, bad;
    reset = 1'b1; op_start = 1'b0; configreg = '0; in_we = '0; in_wdata = '0;
    fifo_almostfull = 1'b0;

    // rst start cfg we d faf | we data done busy cnt af
    // Single ch2 len3, non-active strobes ignored, extra D/E not written
    vecs.push_back(mk(0,1,32'h0003_0020,4'b0000,8'h0,0, 0,32'h0,  0,1,16'd0,4'b1011));
    vecs.push_back(mk(0,0,32'h0003_0020,4'b1011,8'h1,0, 0,32'h0,  0,1,16'd0,4'b1011));
    vecs.push_back(mk(0,0,32'h0003_0020,4'b0100,8'hA,0, 1,32'h20A,0,1,16'd1,4'b1011));
    vecs.push_back(mk(0,0,32'h0003_0020,4'b0100,8'hB,0, 1,32'h20B,0,1,16'd2,4'b1011));
    vecs.push_back(mk(0,0,32'h0003_0020,4'b0100,8'hC,0, 1,32'h20C,1,0,16'd3,4'b1111));
    vecs.push_back(mk(0,0,32'h0003_0020,4'b0100,8'hD,0, 0,32'h0,  0,0,16'd3,4'b1111));
    vecs.push_back(mk(0,0,32'h0003_0020,4'b0100,8'hE,0, 0,32'h0,  0,0,16'd3,4'b1111));
    // Round-robin len6, all sources streaming
    vecs.push_back(mk(0,1,32'h0006_0001,4'b0000,8'h0,0, 0,32'h0,  0,1,16'd0,4'b1110));
    vecs.push_back(mk(0,0,32'h0006_0001,4'b1111,8'h0,0, 1,32'h000,0,1,16'd1,4'b1101));
    vecs.push_back(mk(0,0,32'h0006_0001,4'b1111,8'h0,0, 1,32'h100,0,1,16'd2,4'b1011));
    vecs.push_back(mk(0,0,32'h0006_0001,4'b1111,8'h0,0, 1,32'h200,0,1,16'd3,4'b0111));
    vecs.push_back(mk(0,0,32'h0006_0001,4'b1111,8'h0,0, 1,32'h300,0,1,16'd4,4'b1110));
    vecs.push_back(mk(0,0,32'h0006_0001,4'b1111,8'h0,0, 1,32'h000,0,1,16'd5,4'b1101));
    vecs.push_back(mk(0,0,32'h0006_0001,4'b1111,8'h0,0, 1,32'h100,1,0,16'd6,4'b1111));
    vecs.push_back(mk(0,0,32'h0006_0001,4'b1111,8'h0,0, 0,32'h0,  0,0,16'd6,4'b1111));
    // Length 0: done next cycle, count cleared, nothing written
    vecs.push_back(mk(0,1,32'h0000_0020,4'b0000,8'h0,0, 0,32'h0,  1,0,16'd0,4'b1111));
    vecs.push_back(mk(0,0,32'h0000_0020,4'b1111,8'h0,0, 0,32'h0,  0,0,16'd0,4'b1111));
    // Single ch7 with 4 channels: rejected
    vecs.push_back(mk(0,1,32'h0004_0070,4'b0000,8'h0,0, 0,32'h0,  1,0,16'd0,4'b1111));
    vecs.push_back(mk(0,0,32'h0004_0070,4'b1111,8'h0,0, 0,32'h0,  0,0,16'd0,4'b1111));
    vecs.push_back(mk(0,0,32'h0004_0070,4'b1111,8'h0,0, 0,32'h0,  0,0,16'd0,4'b1111));
    // Mode 2'b10 behaves as single, ch1 len2
    vecs.push_back(mk(0,1,32'h0002_0012,4'b0000,8'h0,0, 0,32'h0,  0,1,16'd0,4'b1101));
    vecs.push_back(mk(0,0,32'h0002_0012,4'b1111,8'h5,0, 1,32'h105,0,1,16'd1,4'b1101));
    vecs.push_back(mk(0,0,32'h0002_0012,4'b1111,8'h5,0, 1,32'h105,1,0,16'd2,4'b1111));
    // RR len3 with fifo_almostfull episodes and an ignored op_start in RUN
    vecs.push_back(mk(0,1,32'h0003_0001,4'b0000,8'h0,0, 0,32'h0,  0,1,16'd0,4'b1110));
    vecs.push_back(mk(0,1,32'h0000_0000,4'b0000,8'h0,1, 0,32'h0,  0,1,16'd0,4'b1111));
    vecs.push_back(mk(0,0,32'h0003_0001,4'b1111,8'h0,0, 1,32'h000,0,1,16'd1,4'b1101));
    vecs.push_back(mk(0,0,32'h0003_0001,4'b0000,8'h0,1, 0,32'h0,  0,1,16'd1,4'b1111));
    vecs.push_back(mk(0,0,32'h0003_0001,4'b1111,8'h0,0, 1,32'h100,0,1,16'd2,4'b1011));
    vecs.push_back(mk(0,0,32'h0003_0001,4'b1111,8'h0,0, 1,32'h200,1,0,16'd3,4'b1111));
    // Reset after 2 of 5 lines, then a clean length-1 operation
    vecs.push_back(mk(0,1,32'h0005_0010,4'b0000,8'h0,0, 0,32'h0,  0,1,16'd0,4'b1101));
    vecs.push_back(mk(0,0,32'h0005_0010,4'b0010,8'h1,0, 1,32'h101,0,1,16'd1,4'b1101));
    vecs.push_back(mk(0,0,32'h0005_0010,4'b0010,8'h2,0, 1,32'h102,0,1,16'd2,4'b1101));
    vecs.push_back(mk(1,0,32'h0005_0010,4'b0010,8'h3,0, 0,32'h0,  0,0,16'd0,4'b1111));
    vecs.push_back(mk(0,0,32'h0005_0010,4'b0010,8'h4,0, 0,32'h0,  0,0,16'd0,4'b1111));
    vecs.push_back(mk(0,1,32'h0001_0010,4'b0000,8'h0,0, 0,32'h0,  0,1,16'd0,4'b1101));
    vecs.push_back(mk(0,0,32'h0001_0010,4'b0010,8'h9,0, 1,32'h109,1,0,16'd1,4'b1111));
    vecs.push_back(mk(0,0,32'h0001_0010,4'b0010,8'h9,0, 0,32'h0,  0,0,16'd1,4'b1111));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset fifo_we", 32'(fifo_we), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset lines_written", 32'(lines_written), 32'd0);
    check("reset in_almostfull", 32'(in_almostfull), 32'hF);

    // Table-driven cycles
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; op_start = vecs[i].start; configreg = vecs[i].cfg;
      in_we = vecs[i].we; fifo_almostfull = vecs[i].faf; set_data(vecs[i].d);
      @(posedge clk);
      #1;
      check($sformatf("v%0d fifo_we", i), 32'(fifo_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) check($sformatf("v%0d fifo_wdata", i), fifo_wdata, vecs[i].e_data);
      check($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d lines_written", i), 32'(lines_written), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d in_almostfull", i), 32'(in_almostfull), 32'(vecs[i].e_af));
    end

    // Maximum length 0xFFFF on channel 0: must finish with no count wrap
    @(negedge clk);
    reset = 1'b0; op_start = 1'b1; configreg = 32'hFFFF_0000; in_we = '0;
    fifo_almostfull = 1'b0; set_data(8'h77);
    @(posedge clk);
    #1;
    check("maxlen busy after start", 32'(busy), 32'd1);
    @(negedge clk);
    op_start = 1'b0; in_we = 4'b0001;
    writes = 0; dones = 0; bad = 0;
    for (int k = 0; k < 65540; k++) begin
      @(posedge clk);
      #1;
      if (fifo_we) begin
        writes++;
        if (fifo_wdata !== 32'h77) bad++;
      end
      if (done) begin
        dones++;
        if (!fifo_we) bad++;
      end
    end
    check("maxlen writes", 32'(writes), 32'd65535);
    check("maxlen done pulses", 32'(dones), 32'd1);
    check("maxlen bad beats", 32'(bad), 32'd0);
    check("maxlen lines_written", 32'(lines_written), 32'hFFFF);
    check("maxlen busy at end", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
